// File: rtl/dt_pkg.sv
// Shared constants and FSM state type for the distance-map peak scanner.
package dt_pkg;

  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int ADDR_W = 14;
  localparam int PIX_W  = 8;
  localparam int COL_W  = 7;
  localparam int ROW_W  = ADDR_W - COL_W;
  localparam int AREA_W = 15;

  localparam logic [ADDR_W-1:0] LAST_ADDR = 14'd16383;
  localparam logic [AREA_W-1:0] AREA_MAX  = 15'd16384;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/dt_peak_scan.sv
// Single-pass scan of the 128x128 distance map: reports the first maximum and its position.
// Optional object-area counter enabled by defining DT_PEAK_AREA_EN.
module dt_peak_scan
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              res_rd,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [PIX_W-1:0]  res_di,
  output logic              busy,
  output logic              done,
  output logic [PIX_W-1:0]  max_val,
  output logic [ROW_W-1:0]  max_row,
  output logic [COL_W-1:0]  max_col,
  output logic [AREA_W-1:0] area
);

  scan_state_e state_q, state_d;

  logic              scan_start;
  logic              last_issue;
  logic              smp_vld;
  logic [ADDR_W-1:0] smp_addr;

  assign scan_start = (state_q == IDLE) && start;
  assign last_issue = (state_q == READ) && (res_addr == LAST_ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (last_issue) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == READ) || (state_q == DRAIN);
    done = (state_q == DONE);
  end

  // Address stays put after the last issue so the RAM port is quiet between scans.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_rd   <= 1'b0;
      res_addr <= '0;
    end else if (scan_start) begin
      res_rd   <= 1'b1;
      res_addr <= '0;
    end else if (last_issue) begin
      res_rd   <= 1'b0;
    end else if (state_q == READ) begin
      res_addr <= res_addr + 14'd1;
    end
  end

  // One-cycle delay lines up the issued address with the returned data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp_vld  <= 1'b0;
      smp_addr <= '0;
    end else begin
      smp_vld  <= res_rd;
      smp_addr <= res_addr;
    end
  end

  // Strict greater-than keeps the earliest raster position on ties.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_val <= '0;
      max_row <= '0;
      max_col <= '0;
    end else if (scan_start) begin
      max_val <= '0;
      max_row <= '0;
      max_col <= '0;
    end else if (smp_vld && (res_di > max_val)) begin
      max_val <= res_di;
      max_row <= smp_addr[ADDR_W-1:COL_W];
      max_col <= smp_addr[COL_W-1:0];
    end
  end

`ifdef DT_PEAK_AREA_EN
  logic [AREA_W-1:0] area_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      area_q <= '0;
    end else if (scan_start) begin
      area_q <= '0;
    end else if (smp_vld && (res_di != '0) && (area_q != AREA_MAX)) begin
      area_q <= area_q + 15'd1;
    end
  end

  assign area = area_q;
`else
  assign area = '0;
`endif

endmodule

// File: tb/tb_dt_peak_scan.sv
// Bench for dt_peak_scan: table-driven scans plus abort/restart sequence, scoreboard of expected results.
module tb_dt_peak_scan;
  import dt_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di = 8'd0;
  logic        busy;
  logic        done;
  logic [7:0]  max_val;
  logic [6:0]  max_row;
  logic [6:0]  max_col;
  logic [14:0] area;

  // clock / reset
  always #5 clk = ~clk;

  dt_peak_scan dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .res_rd   (res_rd),
    .res_addr (res_addr),
    .res_di   (res_di),
    .busy     (busy),
    .done     (done),
    .max_val  (max_val),
    .max_row  (max_row),
    .max_col  (max_col),
    .area     (area)
  );

  // result RAM model, one-cycle read latency
  logic [7:0] mem [16384];
  always @(posedge clk) if (res_rd) res_di <= mem[res_addr];

  // free-running monitors; tests use deltas of these counters
  int          done_cnt = 0;
  int          rd_cnt = 0;
  int          addr_err = 0;
  logic        prev_rd = 1'b0;
  logic [13:0] prev_addr = 14'd0;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (res_rd) begin
      if (res_addr !== (prev_rd ? prev_addr + 14'd1 : 14'd0)) addr_err++;
      rd_cnt++;
    end
    prev_rd   = res_rd;
    prev_addr = res_addr;
  end

  // scoreboard: {max_val, max_row, max_col, area}
  logic [36:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [13:0] a0;
    logic [7:0]  v0;
    logic [13:0] a1;
    logic [7:0]  v1;
    logic        extra_start;
    logic [7:0]  e_max;
    logic [6:0]  e_row;
    logic [6:0]  e_col;
    logic [14:0] e_area;
  } vec_t;
  vec_t vecs[3];

  function automatic logic [14:0] exp_area(input logic [14:0] a);
`ifdef DT_PEAK_AREA_EN
    return a;
`else
    return 15'd0;
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  task automatic load_map(input logic [13:0] a0, input logic [7:0] v0,
                          input logic [13:0] a1, input logic [7:0] v1);
    for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
    if (v0 != 8'd0) mem[a0] = v0;
    if (v1 != 8'd0) mem[a1] = v1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // counts cycles from t1; returns the cycle index in which done was seen
  task automatic wait_done(input logic extra, output int cnt);
    cnt = 1;
    forever begin
      @(negedge clk);
      if (done) break;
      if (cnt == 2) check("busy_in_scan", {31'd0, busy}, 32'd1);
      start = (extra && cnt == 1000);
      cnt++;
      if (cnt > 20000) break;
    end
    start = 1'b0;
  endtask

  task automatic check_results(input string tag);
    logic [36:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_max_val"}, {24'd0, max_val}, {24'd0, e[36:29]});
    check({tag, "_max_row"}, {25'd0, max_row}, {25'd0, e[28:22]});
    check({tag, "_max_col"}, {25'd0, max_col}, {25'd0, e[21:15]});
    check({tag, "_area"},    {17'd0, area},    {17'd0, e[14:0]});
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_stable_val"}, {24'd0, max_val}, {24'd0, e[36:29]});
    check({tag, "_stable_pos"}, {18'd0, max_row, max_col}, {18'd0, e[28:15]});
    check({tag, "_rd_idle"}, {31'd0, res_rd}, 32'd0);
    check({tag, "_addr_hold"}, {18'd0, res_addr}, 32'd16383);
  endtask

  task automatic run_scan(input string tag, input logic extra,
                          input logic [7:0] mx, input logic [6:0] row,
                          input logic [6:0] col, input logic [14:0] ar);
    int cnt, d0, r0, e0;
    d0 = done_cnt; r0 = rd_cnt; e0 = addr_err;
    exp_q.push_back({mx, row, col, ar});
    pulse_start();
    wait_done(extra, cnt);
    check({tag, "_latency"}, cnt, 32'd16386);
    if (done) check_results(tag);
    else exp_q.delete();
    check({tag, "_done_count"}, done_cnt - d0, 32'd1);
    check({tag, "_rd_count"}, rd_cnt - r0, 32'd16384);
    check({tag, "_addr_seq_err"}, addr_err - e0, 32'd0);
  endtask

  initial begin
    int d0;
    vecs[0] = '{14'd0,   8'd0, 14'd0,   8'd0, 1'b0, 8'd0, 7'd0,  7'd0,   exp_area(15'd0)};
    vecs[1] = '{14'd8320, 8'd5, 14'd0,  8'd0, 1'b0, 8'd5, 7'd65, 7'd0,   exp_area(15'd1)};
    vecs[2] = '{14'd100, 8'd9, 14'd200, 8'd9, 1'b1, 8'd9, 7'd0,  7'd100, exp_area(15'd2)};

    #23;
    check("rst_res_rd",   {31'd0, res_rd},   32'd0);
    check("rst_res_addr", {18'd0, res_addr}, 32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_max_val",  {24'd0, max_val},  32'd0);
    check("rst_max_pos",  {18'd0, max_row, max_col}, 32'd0);
    check("rst_area",     {17'd0, area},     32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      load_map(vecs[i].a0, vecs[i].v0, vecs[i].a1, vecs[i].v1);
      run_scan($sformatf("vec%0d", i), vecs[i].extra_start,
               vecs[i].e_max, vecs[i].e_row, vecs[i].e_col, vecs[i].e_area);
      repeat (2) @(negedge clk);
    end

    // abort at t5000 with an asynchronous reset, then a clean rescan
    load_map(14'd16383, 8'd255, 14'd0, 8'd0);
    d0 = done_cnt;
    exp_q.push_back({8'd255, 7'd127, 7'd127, exp_area(15'd1)});
    pulse_start();
    for (int k = 1; k <= 5000; k++) @(negedge clk);
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_res_rd",   {31'd0, res_rd},   32'd0);
    check("abort_res_addr", {18'd0, res_addr}, 32'd0);
    check("abort_busy",     {31'd0, busy},     32'd0);
    check("abort_done",     {31'd0, done},     32'd0);
    check("abort_max_val",  {24'd0, max_val},  32'd0);
    check("abort_area",     {17'd0, area},     32'd0);
    exp_q.delete();
    repeat (30) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 32'd0);
    run_scan("rescan", 1'b0, 8'd255, 7'd127, 7'd127, exp_area(15'd1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
